axi_mem_responder: RTL

AXI4 slave-side responder with an internal word-addressed memory, acting as the far end of the master interface driven by the testbench agents. It accepts write bursts (AW/W/B) and read bursts (AR/R) concurrently, with one outstanding transaction per direction. It serves as the DDR-controller stand-in and the self-check target for master-side sequences.

---
 rtl/axi_mem_responder_if.sv | 70 +++++++
 rtl/axi_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AXI4 AW/W/B/AR/R channel bundle for the memory responder
// Purpose: groups the five AXI4 channels (no lock/cache/prot) into one port.
// Modports: master drives AW/W/AR payloads, valids, bready and rready;
//           slave drives awready/wready/arready and the B and R channels.

interface axi_mem_responder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave responder backed by an internal word memory
// Purpose: services one write burst and one read burst at a time, independently,
//          against a DEPTH x DATA_W memory (lock/cache/prot are not modelled).
// Ports:   aclk    - clock
//          aresetn - asynchronous active-low reset
//          axi     - slave modport of axi_mem_responder_if (AW/W/B/AR/R)

module axi_mem_responder #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic               aclk,
  input  logic               aresetn,
  axi_mem_responder_if.slave axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]      MAX_SIZE = 3'(OFF);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Memory is intentionally not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // A beat is serviceable only if its size fits the bus and its word exists.
  function automatic logic beat_ok(input logic [ADDR_W-1:0] a, input logic [2:0] size);
    logic [ADDR_W:0] word;
    word = {1'b0, a >> OFF};
    return (size <= MAX_SIZE) && (word < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF);
  endfunction

  // Returns {error, effective burst}. Illegal WRAP and reserved type 11 run as INCR.
  function automatic logic [2:0] burst_eval(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    logic              wrap_ok;
    step    = ADDR_W'(1) << size;
    wrap_ok = ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) &&
              ((a & (step - ADDR_W'(1))) == '0);
    case (burst)
      BURST_FIXED: return {1'b0, BURST_FIXED};
      BURST_INCR:  return {1'b0, BURST_INCR};
      BURST_WRAP:  return wrap_ok ? {1'b0, BURST_WRAP} : {1'b1, BURST_INCR};
      default:     return {1'b1, BURST_INCR};
    endcase
  endfunction

  // WRAP keeps the container base and lets the incremented offset roll over
  // inside the (len+1)<<size window; all sums wrap mod 2^ADDR_W naturally.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step, incr, cmask;
    step  = ADDR_W'(1) << size;
    incr  = (a & ~(step - ADDR_W'(1))) + step;
    cmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~cmask) | (incr & cmask);
      default:     return incr;
    endcase
  endfunction

  // ---------------- write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              werr_q, werr_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [2:0]        aw_eval;
  logic              w_last_beat;
  logic              mem_we;

  always_comb begin
    w_state_d   = w_state_q;
    wid_d       = wid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wsize_d     = wsize_q;
    wburst_d    = wburst_q;
    werr_d      = werr_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    w_last_beat = (wcnt_q == wlen_q);
    aw_eval     = burst_eval(axi.awaddr, axi.awlen, axi.awsize, axi.awburst);
    case (w_state_q)
      W_IDLE: begin
        if (axi.awvalid && awready_q) begin
          wid_d     = axi.awid;
          waddr_d   = axi.awaddr;
          wlen_d    = axi.awlen;
          wsize_d   = axi.awsize;
          wburst_d  = aw_eval[1:0];
          wcnt_d    = 8'd0;
          werr_d    = aw_eval[2];
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.wvalid && wready_q) begin
          if (beat_ok(waddr_q, wsize_q)) mem_we = 1'b1;
          else                           werr_d = 1'b1;
          // The beat count alone ends the burst; a misplaced wlast only flags it.
          if (axi.wlast != w_last_beat) werr_d = 1'b1;
          waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            bid_d     = wid_q;
            bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (axi.bready && bvalid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readies/valids are registered copies of the next state so they are all
    // low in reset and awready rises one edge after release.
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic              rberr_q, rberr_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [2:0]        ar_eval;
  logic              r_load, r_ok, ld_berr;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_size;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rberr_d   = rberr_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    ld_addr   = raddr_q;
    ld_size   = rsize_q;
    ld_berr   = rberr_q;
    ar_eval   = burst_eval(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
    case (r_state_q)
      R_IDLE: begin
        if (axi.arvalid && arready_q) begin
          rid_d     = axi.arid;
          raddr_d   = axi.araddr;
          rlen_d    = axi.arlen;
          rsize_d   = axi.arsize;
          rburst_d  = ar_eval[1:0];
          rberr_d   = ar_eval[2];
          rcnt_d    = 8'd0;
          rlast_d   = (axi.arlen == 8'd0);
          r_load    = 1'b1;
          ld_addr   = axi.araddr;
          ld_size   = axi.arsize;
          ld_berr   = ar_eval[2];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && axi.rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            // Load the following beat on the accepting edge for back-to-back beats.
            ld_addr = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
            raddr_d = ld_addr;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Combinational array read: a write landing on the same edge is not seen.
    r_ok = beat_ok(ld_addr, ld_size);
    if (r_load) begin
      rdata_d = r_ok ? mem[word_idx(ld_addr)] : '0;
      rresp_d = (r_ok && !ld_berr) ? RESP_OKAY : RESP_SLVERR;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rberr_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rberr_q   <= rberr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.arready = arready_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.rvalid  = rvalid_q;
endmodule
